// File: rtl/fp_pkg.sv
// Shared definitions for the FP add/sub issue path: FSM states, IEEE-754 constants, sign helper.
package fp_pkg;

    localparam int unsigned FP_W         = 32;
    localparam int unsigned FP_REG_IDX_W = 5;
    localparam int unsigned FP_SIGN_BIT  = 31;

    localparam logic [FP_W-1:0] FP_CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_WB      = 2'd3
    } fp_state_e;

    // Subtraction is a + (-b): only the sign bit of b changes, NaN payloads pass through.
    function automatic logic [FP_W-1:0] fp_flip_sign(input logic [FP_W-1:0] x, input logic neg);
        logic [FP_W-1:0] mask;
        mask              = '0;
        mask[FP_SIGN_BIT] = neg;
        return x ^ mask;
    endfunction

endpackage

// File: rtl/fp_issue_timer.sv
// RUN-state watchdog for fp_issue_ctrl; instantiated only when FP_ISSUE_TIMEOUT_EN is defined.
module fp_issue_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired_c
);

    localparam int unsigned CNT_RAW_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W     = (CNT_RAW_W > 8) ? CNT_RAW_W : 8;

    logic [CNT_W-1:0] cnt_q;

    // Counts RUN cycles since the last accept; saturates once expired.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (run && !expired_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_c = run && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fp_issue_ctrl.sv
// Issue/handshake/writeback controller for the multi-cycle FP add/sub unit.
// Optional RUN timeout with sticky timeout_err: define FP_ISSUE_TIMEOUT_EN.
module fp_issue_ctrl
    import fp_pkg::*;
`ifdef FP_ISSUE_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
)
`endif
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic [FP_W-1:0]         issue_a,
    input  logic [FP_W-1:0]         issue_b,
    input  logic                    issue_sub,
    input  logic [FP_REG_IDX_W-1:0] issue_rd,
    output logic                    fp_start,
    output logic [FP_W-1:0]         fp_a,
    output logic [FP_W-1:0]         fp_b,
    input  logic                    fp_done,
    input  logic [FP_W-1:0]         fp_result,
    output logic                    wb_en,
    output logic [FP_REG_IDX_W-1:0] wb_rd,
    output logic [FP_W-1:0]         wb_data,
`ifdef FP_ISSUE_TIMEOUT_EN
    output logic                    timeout_err,
`endif
    output logic                    stall
);

    fp_state_e               state_q;
    fp_state_e               state_n;
    logic                    accept_c;
    logic                    capture_c;
    logic                    timeout_c;
    logic                    expired_c;
    logic [FP_REG_IDX_W-1:0] rd_q;
    logic [FP_W-1:0]         result_q;

`ifdef FP_ISSUE_TIMEOUT_EN
    fp_issue_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept_c),
        .run       (state_q == ST_RUN),
        .expired_c (expired_c)
    );
`else
    assign expired_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        timeout_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue_valid) begin
                    accept_c = 1'b1;
                    state_n  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fp_done) begin
                    capture_c = 1'b1;
                    state_n   = ST_RELEASE;
                end else if (expired_c) begin
                    timeout_c = 1'b1;
                    state_n   = ST_RELEASE;
                end
            end
            // Wait for the FP unit to drop done so it is idle before the next start.
            ST_RELEASE: begin
                if (!fp_done) begin
                    state_n = ST_WB;
                end
            end
            ST_WB: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from next state, so nothing combinational leaks from fp_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_ready <= 1'b1;
            stall       <= 1'b0;
            fp_start    <= 1'b0;
            fp_a        <= '0;
            fp_b        <= '0;
            wb_en       <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            rd_q        <= '0;
            result_q    <= '0;
`ifdef FP_ISSUE_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
        end else begin
            issue_ready <= (state_n == ST_IDLE);
            stall       <= (state_n != ST_IDLE);
            fp_start    <= (state_n == ST_RUN);
            wb_en       <= (state_n == ST_WB);
            if (accept_c) begin
                fp_a <= issue_a;
                fp_b <= fp_flip_sign(issue_b, issue_sub);
                rd_q <= issue_rd;
            end
            if (capture_c) begin
                result_q <= fp_result;
            end else if (timeout_c) begin
                result_q <= FP_CANON_NAN;
            end
            if (state_n == ST_WB) begin
                wb_rd   <= rd_q;
                wb_data <= result_q;
            end
`ifdef FP_ISSUE_TIMEOUT_EN
            if (timeout_c) begin
                timeout_err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed bench for fp_issue_ctrl with a behavioural FP unit model (latency/release configurable).
module tb_fp_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic        issue_sub;
    logic [4:0]  issue_rd;
    logic        fp_start;
    logic [31:0] fp_a;
    logic [31:0] fp_b;
    logic        fp_done;
    logic [31:0] fp_result;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
`ifdef FP_ISSUE_TIMEOUT_EN
    logic        timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    // FP unit model controls: lat = cycles of start before done (0 = never), hold = done cycles after start falls
    int          lat;
    int          hold;
    logic [31:0] model_res;
    int          mcnt;
    int          mrel;

    always #5 clk = ~clk;

`ifdef FP_ISSUE_TIMEOUT_EN
    fp_issue_ctrl #(.TIMEOUT_CYCLES(16)) dut (
`else
    fp_issue_ctrl dut (
`endif
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_a     (issue_a),
        .issue_b     (issue_b),
        .issue_sub   (issue_sub),
        .issue_rd    (issue_rd),
        .fp_start    (fp_start),
        .fp_a        (fp_a),
        .fp_b        (fp_b),
        .fp_done     (fp_done),
        .fp_result   (fp_result),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
`ifdef FP_ISSUE_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .stall       (stall)
    );

    always @(posedge clk) begin
        if (rst) begin
            fp_done   <= 1'b0;
            fp_result <= '0;
            mcnt      <= 0;
            mrel      <= 0;
        end else if (fp_start && !fp_done) begin
            if (lat != 0 && mcnt == lat - 1) begin
                fp_done   <= 1'b1;
                fp_result <= model_res;
            end
            mcnt <= mcnt + 1;
        end else if (!fp_start && fp_done) begin
            if (mrel == hold - 1) fp_done <= 1'b0;
            mrel <= mrel + 1;
        end else if (!fp_start) begin
            mcnt <= 0;
            mrel <= 0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction for a single edge; returns in cycle N+1 (t=1).
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [4:0] rd, input logic keep);
        issue_valid = 1'b1;
        issue_a     = a;
        issue_b     = b;
        issue_sub   = sub;
        issue_rd    = rd;
        tick();
        if (!keep) issue_valid = 1'b0;
    endtask

    // Steps until IDLE (bounded), recording writeback and stall/start behaviour.
    task automatic wait_wb(input int t0, output int wb_t, output int wb_cnt, output int idle_t,
                           output int rises, output int stall_bad,
                           output logic [4:0] rd, output logic [31:0] data);
        int   t  = t0;
        logic ps = fp_start;
        wb_t = -1; wb_cnt = 0; idle_t = -1; rises = 0; stall_bad = 0; rd = '0; data = '0;
        for (int i = 0; i < 200; i++) begin
            tick();
            t++;
            if (fp_start && !ps) rises++;
            ps = fp_start;
            if (wb_en) begin
                wb_cnt++;
                wb_t = t;
                rd   = wb_rd;
                data = wb_data;
            end
            if (issue_ready) begin
                idle_t = t;
                break;
            end
            if (!stall) stall_bad++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %b expected 1", issue_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (fp_start !== 1'b0) begin errors++; $display("FAIL reset_fp_start: got %b expected 0", fp_start); end
        checks++; if ({fp_a, fp_b} !== 64'h0) begin errors++; $display("FAIL reset_operands: got %h %h expected 0 0", fp_a, fp_b); end
        checks++; if ({wb_en, wb_rd, wb_data} !== 38'h0) begin errors++; $display("FAIL reset_wb: got en=%b rd=%0d data=%h expected all 0", wb_en, wb_rd, wb_data); end
`ifdef FP_ISSUE_TIMEOUT_EN
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add;
        int wb_t, wb_cnt, idle_t, rises, stall_bad;
        logic [4:0]  rd;
        logic [31:0] data;
        lat = 5; hold = 1; model_res = 32'h4040_0000;
        issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd3, 1'b0);
        checks++; if (fp_start !== 1'b1) begin errors++; $display("FAIL add_start: got %b expected 1", fp_start); end
        checks++; if (stall !== 1'b1 || issue_ready !== 1'b0) begin errors++; $display("FAIL add_stall_ready: got stall=%b ready=%b expected 1 0", stall, issue_ready); end
        checks++; if (fp_a !== 32'h3F80_0000) begin errors++; $display("FAIL add_fp_a: got %h expected 3f800000", fp_a); end
        checks++; if (fp_b !== 32'h4000_0000) begin errors++; $display("FAIL add_fp_b: got %h expected 40000000", fp_b); end
        wait_wb(1, wb_t, wb_cnt, idle_t, rises, stall_bad, rd, data);
        checks++; if (wb_cnt !== 1) begin errors++; $display("FAIL add_wb_count: got %0d expected 1", wb_cnt); end
        checks++; if (wb_t !== 9) begin errors++; $display("FAIL add_wb_cycle: got %0d expected 9", wb_t); end
        checks++; if (rd !== 5'd3 || data !== 32'h4040_0000) begin errors++; $display("FAIL add_wb_payload: got rd=%0d data=%h expected rd=3 data=40400000", rd, data); end
        checks++; if (idle_t !== 10) begin errors++; $display("FAIL add_idle_cycle: got %0d expected 10", idle_t); end
        checks++; if (stall_bad !== 0 || stall !== 1'b0) begin errors++; $display("FAIL add_stall_window: got low_cycles=%0d idle_stall=%b expected 0 0", stall_bad, stall); end
    endtask

    task automatic test_sub;
        int wb_t, wb_cnt, idle_t, rises, stall_bad;
        logic [4:0]  rd;
        logic [31:0] data;
        lat = 2; hold = 1; model_res = 32'h4000_0000;
        issue(32'h4040_0000, 32'h3F80_0000, 1'b1, 5'd17, 1'b0);
        checks++; if (fp_b !== 32'hBF80_0000) begin errors++; $display("FAIL sub_fp_b: got %h expected bf800000", fp_b); end
        checks++; if (fp_a !== 32'h4040_0000) begin errors++; $display("FAIL sub_fp_a: got %h expected 40400000", fp_a); end
        wait_wb(1, wb_t, wb_cnt, idle_t, rises, stall_bad, rd, data);
        checks++; if (wb_cnt !== 1 || rd !== 5'd17 || data !== 32'h4000_0000) begin errors++; $display("FAIL sub_wb: got n=%0d rd=%0d data=%h expected n=1 rd=17 data=40000000", wb_cnt, rd, data); end
        checks++; if (wb_t !== 6) begin errors++; $display("FAIL sub_wb_cycle: got %0d expected 6", wb_t); end
    endtask

    task automatic test_busy_ignore;
        int wb_t, wb_cnt, idle_t, rises, stall_bad, extra;
        logic [4:0]  rd;
        logic [31:0] data;
        lat = 3; hold = 1; model_res = 32'h1111_1111;
        issue(32'hAAAA_0001, 32'h7FC0_0001, 1'b1, 5'd5, 1'b1);
        issue_a = 32'h5555_0002; issue_b = 32'h0000_0003; issue_sub = 1'b0; issue_rd = 5'd9;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b expected 0", issue_ready); end
            checks++; if (fp_a !== 32'hAAAA_0001 || fp_b !== 32'hFFC0_0001) begin errors++; $display("FAIL busy_operands: got %h %h expected aaaa0001 ffc00001", fp_a, fp_b); end
        end
        wait_wb(3, wb_t, wb_cnt, idle_t, rises, stall_bad, rd, data);
        checks++; if (wb_cnt !== 1 || rd !== 5'd5 || data !== 32'h1111_1111) begin errors++; $display("FAIL busy_first_wb: got n=%0d rd=%0d data=%h expected n=1 rd=5 data=11111111", wb_cnt, rd, data); end
        checks++; if (rises !== 0) begin errors++; $display("FAIL busy_early_accept: got %0d starts before idle expected 0", rises); end
        model_res = 32'h2222_2222;
        tick();
        issue_valid = 1'b0;
        checks++; if (fp_start !== 1'b1 || fp_a !== 32'h5555_0002 || fp_b !== 32'h0000_0003) begin errors++; $display("FAIL busy_second_accept: got start=%b a=%h b=%h expected 1 55550002 00000003", fp_start, fp_a, fp_b); end
        wait_wb(1, wb_t, wb_cnt, idle_t, rises, stall_bad, rd, data);
        checks++; if (wb_cnt !== 1 || rd !== 5'd9 || data !== 32'h2222_2222) begin errors++; $display("FAIL busy_second_wb: got n=%0d rd=%0d data=%h expected n=1 rd=9 data=22222222", wb_cnt, rd, data); end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (fp_start) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL busy_accept_once: got %0d extra start cycles expected 0", extra); end
    endtask

    task automatic test_slow_release;
        int wb_t, wb_cnt, idle_t, rises, stall_bad;
        logic [4:0]  rd;
        logic [31:0] data;
        lat = 2; hold = 3; model_res = 32'hC0A0_0000;
        issue(32'h4000_0000, 32'h40E0_0000, 1'b1, 5'd31, 1'b0);
        wait_wb(1, wb_t, wb_cnt, idle_t, rises, stall_bad, rd, data);
        checks++; if (wb_t !== 8) begin errors++; $display("FAIL slow_wb_cycle: got %0d expected 8", wb_t); end
        checks++; if (rises !== 0) begin errors++; $display("FAIL slow_restart: got %0d restarts expected 0", rises); end
        checks++; if (wb_cnt !== 1 || rd !== 5'd31 || data !== 32'hC0A0_0000) begin errors++; $display("FAIL slow_wb: got n=%0d rd=%0d data=%h expected n=1 rd=31 data=c0a00000", wb_cnt, rd, data); end
        checks++; if (idle_t !== 9 || stall_bad !== 0) begin errors++; $display("FAIL slow_idle: got idle=%0d stall_low=%0d expected 9 0", idle_t, stall_bad); end
    endtask

    task automatic test_reset_mid_run;
        int wbs;
        lat = 10; hold = 1; model_res = 32'hDEAD_BEEF;
        issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 5'd7, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        checks++; if (fp_start !== 1'b0) begin errors++; $display("FAIL rstrun_start: got %b expected 0", fp_start); end
        checks++; if (issue_ready !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL rstrun_idle: got ready=%b stall=%b expected 1 0", issue_ready, stall); end
        rst = 1'b0;
        wbs = 0;
        for (int i = 0; i < 15; i++) begin
            if (wb_en || fp_start) wbs++;
            tick();
        end
        checks++; if (wbs !== 0) begin errors++; $display("FAIL rstrun_no_wb: got %0d wb/start cycles expected 0", wbs); end
    endtask

`ifdef FP_ISSUE_TIMEOUT_EN
    task automatic test_timeout;
        int wb_t, wb_cnt, idle_t, rises, stall_bad;
        logic [4:0]  rd;
        logic [31:0] data;
        lat = 0; hold = 1; model_res = 32'h0;
        issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd12, 1'b0);
        for (int t = 2; t <= 16; t++) tick();
        checks++; if (fp_start !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_run16: got start=%b err=%b expected 1 0", fp_start, timeout_err); end
        tick();
        checks++; if (fp_start !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_abort: got start=%b err=%b expected 0 1", fp_start, timeout_err); end
        wait_wb(17, wb_t, wb_cnt, idle_t, rises, stall_bad, rd, data);
        checks++; if (wb_t !== 18 || wb_cnt !== 1 || rd !== 5'd12 || data !== 32'h7FC0_0000) begin errors++; $display("FAIL tmo_wb: got t=%0d n=%0d rd=%0d data=%h expected 18 1 12 7fc00000", wb_t, wb_cnt, rd, data); end
        tick();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b expected 1", timeout_err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b expected 0", timeout_err); end
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_a = '0; issue_b = '0; issue_sub = 1'b0; issue_rd = '0;
        lat = 5; hold = 1; model_res = '0;
        test_reset();
        test_add();
        test_sub();
        test_busy_ignore();
        test_slow_release();
        test_reset_mid_run();
`ifdef FP_ISSUE_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
